tx_ffe_adapter: RTL and testbench
=================================

Name: tx_ffe_adapter

Overview:
- Consumer end of the channel-estimation interface: takes the estimator's 9-bit guess_frequency stream and drives the TX FFE (pre/main/post) tap weights.
- Qualifies a stable guess, maps it to target taps, then ramps the live taps toward the target in bounded steps. Each step is delivered to the FFE over a valid/ack handshake.
- Sits between the TX equalization estimation path and the TX driver FFE.

Parameters:
- FREQ_W, 9, width of guess_frequency
- TAP_W, 8, width of each tap weight (unsigned magnitude)
- FULL_SCALE, 127, pre+main+post sum held constant
- POST_MAX, 63, saturation limit for post tap
- STABLE_COUNT, 4, consecutive agreeing guesses required to qualify
- TOL, 2, max |guess - reference guess| still counted as agreeing
- STEP, 4, max post-tap change per handshake transfer

Ports:
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  adaptation enable
- retrain  in  1  single-cycle pulse; restart qualification
- guess_frequency  in  FREQ_W  estimator output
- guess_valid  in  1  one-cycle strobe, new guess_frequency present
- tap_pre  out  TAP_W  pre-cursor weight
- tap_main  out  TAP_W  main-cursor weight
- tap_post  out  TAP_W  post-cursor weight
- taps_valid  out  1  tap triple offered to FFE
- taps_ack  in  1  FFE accepts triple
- locked  out  1  live taps equal target

Behaviour:
- Reset, asynchronous: tap_pre=0, tap_main=127, tap_post=0, taps_valid=0, locked=0, state=IDLE, stable counter=0, reference guess=0.
- Target map (combinational):
  - tpost = min(guess>>2, POST_MAX)
  - tpre = tpost>>2
  - tmain = FULL_SCALE - tpre - tpost
  - The live triple always obeys the same pre/main derivation from live post, so the sum always equals FULL_SCALE.
- States: IDLE, TRACK, RAMP, LOCKED.
- IDLE:
  - enable=1 -> TRACK, counter=0.
- TRACK, on each guess_valid:
  - If |guess - ref| <= TOL, counter++.
  - Otherwise ref=guess and counter=1.
  - When counter reaches STABLE_COUNT, latch target from ref -> RAMP.
- RAMP:
  - next_post = cur_post moved toward tpost by min(STEP, |diff|).
  - Present the next triple with taps_valid=1.
  - On a cycle with taps_valid&&taps_ack: triple committed; taps_valid drops next cycle. If committed post==tpost, go to LOCKED with locked=1 the next cycle. Otherwise present the next step one cycle after taps_valid drops.
  - If target equals live taps on entry: go directly to LOCKED with no transfer.
- Handshake:
  - Outputs are stable while taps_valid&&!taps_ack.
  - taps_valid never deasserts without ack (except reset).
  - No ack timeout.
- LOCKED:
  - Guesses are ignored.
  - retrain -> TRACK: counter=0, locked=0, live taps held.
- enable=0 in any state -> IDLE, taps held, locked=0. If a transfer is pending, the handshake completes first, then IDLE.
- retrain in TRACK resets the counter. retrain in RAMP is deferred until the current transfer is acked, then -> TRACK.
- guess_valid coincident with retrain: the retrain wins and the guess is dropped.
- The stable counter saturates and never wraps.

Optional Feature:
- TX_FFE_RELOCK_EN defined: LOCKED keeps running TRACK qualification in the background. A newly qualified guess whose tpost differs from the locked tpost causes locked=0 and a return to RAMP toward the new target, with no retrain needed.
- Undefined: LOCKED is exited only via retrain or enable=0.

Decomposition:
- Package tx_ffe_pkg holds:
  - state enum (IDLE, TRACK, RAMP, LOCKED)
  - tap triple struct {pre, main, post}
  - FULL_SCALE, POST_MAX, and width constants
- One sub-module: ffe_target_map, the combinational guess -> tap-triple mapping with saturation. It is reused for both target and per-step triples.

Test Plan:
- Reset then enable; four guess_valid strobes of 200 -> RAMP; transfers post 4,8,...,48,50 (13 acks); final pre=12 main=65 post=50; locked=1.
- Guesses 200,201,199,202,201 -> qualifies on the 4th strobe (ref stays 200, all within TOL=2); the 5th strobe is ignored.
- Guesses 200,200,210,210,210,210 -> counter restarts at 210; target post=52 (210>>2), pre=13, main=62.
- Hold taps_ack=0 for 20 cycles mid-ramp -> taps_valid and the triple stay constant; ack -> next step appears 2 cycles later.
- Guess 400 -> tpost saturates at 63, pre=15, main=49.
- While LOCKED at post=50:
  - Feed four strobes of 100. With macro defined: ramps down to post=25. Without macro: taps unchanged.
  - Then pulse retrain plus four strobes of 100 -> ramps to 25.
- Assert rst_n=0 mid-transfer -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/tx_ffe_pkg.sv
// tx_ffe_pkg: shared types and constants for the TX FFE adapter slice.
//   state_t : adapter FSM states
//   tap_t   : {pre, main, post} tap weight triple
//   FREQ_W, TAP_W, FULL_SCALE, POST_MAX : widths and tap limits
package tx_ffe_pkg;

    localparam int unsigned FREQ_W     = 9;
    localparam int unsigned TAP_W      = 8;
    localparam int unsigned FULL_SCALE = 127;
    localparam int unsigned POST_MAX   = 63;

    typedef enum logic [1:0] {
        IDLE,
        TRACK,
        RAMP,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [TAP_W-1:0] pre;
        logic [TAP_W-1:0] main;
        logic [TAP_W-1:0] post;
    } tap_t;

endpackage

// File: rtl/ffe_target_map.sv
// ffe_target_map: combinational guess -> tap triple mapping.
//   guess : FREQ_W-bit frequency guess (or a post weight pre-scaled by 4)
//   taps  : post = min(guess>>2, POST_MAX), pre = post>>2,
//           main = FULL_SCALE - pre - post
module ffe_target_map
    import tx_ffe_pkg::*;
(
    input  logic [FREQ_W-1:0] guess,
    output tap_t              taps
);

    logic [FREQ_W-1:0] shifted;
    logic [TAP_W-1:0]  post;
    logic [TAP_W-1:0]  pre;

    always_comb begin
        shifted = guess >> 2;
        if (shifted > FREQ_W'(POST_MAX)) begin
            post = TAP_W'(POST_MAX);
        end else begin
            post = TAP_W'(shifted);
        end
        pre       = post >> 2;
        taps.pre  = pre;
        taps.post = post;
        taps.main = TAP_W'(FULL_SCALE) - pre - post;
    end

endmodule

// File: rtl/tx_ffe_adapter.sv
// tx_ffe_adapter: qualifies a stable channel-estimator guess, maps it to
// TX FFE target taps and ramps the live taps toward the target in bounded
// post-tap steps, each step delivered over a valid/ack handshake.
//   clk, rst_n        : clock, asynchronous active-low reset
//   enable            : adaptation enable
//   retrain           : single-cycle pulse, restart qualification
//   guess_frequency   : estimator output, qualified by guess_valid strobe
//   tap_pre/main/post : live (or offered, while taps_valid) tap triple
//   taps_valid/ack    : handshake toward the FFE
//   locked            : live taps equal target
// Optional build macro: TX_FFE_RELOCK_EN keeps qualification running while
// LOCKED and re-ramps on a newly qualified, different target.
module tx_ffe_adapter
    import tx_ffe_pkg::*;
#(
    parameter int unsigned STABLE_COUNT = 4,
    parameter int unsigned TOL          = 2,
    parameter int unsigned STEP         = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              retrain,
    input  logic [FREQ_W-1:0] guess_frequency,
    input  logic              guess_valid,
    output logic [TAP_W-1:0]  tap_pre,
    output logic [TAP_W-1:0]  tap_main,
    output logic [TAP_W-1:0]  tap_post,
    output logic              taps_valid,
    input  logic              taps_ack,
    output logic              locked
);

    localparam int unsigned CNT_W = $clog2(STABLE_COUNT + 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [FREQ_W-1:0]  ref_q, ref_d;
    tap_t               tgt_q, tgt_d;
    logic [TAP_W-1:0]   post_q, post_d;
    logic               valid_q, valid_d;
    logic               locked_q, locked_d;
    logic               pend_q, pend_d;

    // Qualification result for the current guess, before any FSM decision.
    logic [FREQ_W-1:0]  gdiff;
    logic [FREQ_W-1:0]  qual_ref;
    logic [CNT_W-1:0]   qual_cnt;
    logic               qual_hit;
    tap_t               qual_taps;
    tap_t               live_taps;
    logic [TAP_W-1:0]   step_post;

    always_comb begin
        if (guess_frequency >= ref_q) begin
            gdiff = guess_frequency - ref_q;
        end else begin
            gdiff = ref_q - guess_frequency;
        end
        if (gdiff <= FREQ_W'(TOL)) begin
            qual_ref = ref_q;
            if (cnt_q == CNT_W'(STABLE_COUNT)) begin
                qual_cnt = cnt_q;
            end else begin
                qual_cnt = cnt_q + CNT_W'(1);
            end
        end else begin
            qual_ref = guess_frequency;
            qual_cnt = CNT_W'(1);
        end
        qual_hit = (qual_cnt == CNT_W'(STABLE_COUNT));
    end

    ffe_target_map u_target_map (
        .guess (qual_ref),
        .taps  (qual_taps)
    );

    // The live triple reuses the map: post << 2 maps back to post exactly
    // (post never exceeds POST_MAX), giving pre/main from the same rule.
    ffe_target_map u_live_map (
        .guess ({post_q[FREQ_W-3:0], 2'b00}),
        .taps  (live_taps)
    );

    always_comb begin
        if (post_q < tgt_q.post) begin
            if ((tgt_q.post - post_q) > TAP_W'(STEP)) begin
                step_post = post_q + TAP_W'(STEP);
            end else begin
                step_post = tgt_q.post;
            end
        end else begin
            if ((post_q - tgt_q.post) > TAP_W'(STEP)) begin
                step_post = post_q - TAP_W'(STEP);
            end else begin
                step_post = tgt_q.post;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ref_d    = ref_q;
        tgt_d    = tgt_q;
        post_d   = post_q;
        valid_d  = valid_q;
        locked_d = locked_q;
        pend_d   = pend_q;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = TRACK;
                    cnt_d   = '0;
                end
            end

            TRACK: begin
                if (retrain) begin
                    cnt_d = '0;
                end else if (guess_valid) begin
                    ref_d = qual_ref;
                    cnt_d = qual_cnt;
                    if (qual_hit) begin
                        tgt_d   = qual_taps;
                        state_d = RAMP;
                    end
                end
            end

            RAMP: begin
                if (valid_q) begin
                    if (retrain) begin
                        pend_d = 1'b1;
                    end
                    if (taps_ack) begin
                        valid_d = 1'b0;
                        if (pend_q || retrain) begin
                            state_d = TRACK;
                            cnt_d   = '0;
                            pend_d  = 1'b0;
                        end else if (post_q == tgt_q.post) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end
                end else if (retrain) begin
                    state_d = TRACK;
                    cnt_d   = '0;
                end else if (live_taps == tgt_q) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    post_d  = step_post;
                end
            end

            LOCKED: begin
                if (retrain) begin
                    state_d  = TRACK;
                    cnt_d    = '0;
                    locked_d = 1'b0;
                end
`ifdef TX_FFE_RELOCK_EN
                else if (guess_valid) begin
                    ref_d = qual_ref;
                    cnt_d = qual_cnt;
                    if (qual_hit && (qual_taps.post != tgt_q.post)) begin
                        tgt_d    = qual_taps;
                        state_d  = RAMP;
                        locked_d = 1'b0;
                    end
                end
`endif
            end

            default: state_d = IDLE;
        endcase

        // Disable overrides everything except an offered triple still
        // waiting for its ack; that transfer completes first.
        if (!enable && !(valid_q && !taps_ack)) begin
            state_d  = IDLE;
            valid_d  = 1'b0;
            locked_d = 1'b0;
            pend_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            ref_q    <= '0;
            tgt_q    <= '0;
            post_q   <= '0;
            valid_q  <= 1'b0;
            locked_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ref_q    <= ref_d;
            tgt_q    <= tgt_d;
            post_q   <= post_d;
            valid_q  <= valid_d;
            locked_q <= locked_d;
            pend_q   <= pend_d;
        end
    end

    assign tap_pre    = live_taps.pre;
    assign tap_main   = live_taps.main;
    assign tap_post   = live_taps.post;
    assign taps_valid = valid_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_tx_ffe_adapter.sv
module tb_tx_ffe_adapter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       enable = 1'b0;
    logic       retrain = 1'b0;
    logic [8:0] guess_frequency = '0;
    logic       guess_valid = 1'b0;
    logic [7:0] tap_pre, tap_main, tap_post;
    logic       taps_valid;
    logic       taps_ack = 1'b0;
    logic       locked;

    tx_ffe_adapter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .retrain         (retrain),
        .guess_frequency (guess_frequency),
        .guess_valid     (guess_valid),
        .tap_pre         (tap_pre),
        .tap_main        (tap_main),
        .tap_post        (tap_post),
        .taps_valid      (taps_valid),
        .taps_ack        (taps_ack),
        .locked          (locked)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int model_post = 0;
    int exp_q[$];

    typedef struct {
        int g;
        int pre;
        int main;
        int post;
        int xfers;
    } vec_t;

    vec_t tbl[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference target rule: post = min(guess/4, 63).
    function automatic int ref_post(input int g);
        int p;
        p = g / 4;
        if (p > 63) p = 63;
        return p;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b0;
        retrain = 1'b0;
        guess_valid = 1'b0;
        taps_ack = 1'b0;
        guess_frequency = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_post = 0;
        @(negedge clk);
        enable = 1'b1;
        @(negedge clk);
    endtask

    task automatic strobe(input int g);
        @(negedge clk);
        guess_frequency = g[8:0];
        guess_valid = 1'b1;
        @(negedge clk);
        guess_valid = 1'b0;
    endtask

    task automatic strobe4(input int g);
        for (int i = 0; i < 4; i++) strobe(g);
    endtask

    task automatic pulse_retrain();
        @(negedge clk);
        retrain = 1'b1;
        @(negedge clk);
        retrain = 1'b0;
    endtask

    // Expected sequence of committed post values from model_post to tgt.
    task automatic plan(input int tgt);
        int p;
        exp_q.delete();
        p = model_post;
        while (p != tgt) begin
            if (p < tgt) p = (p + 4 > tgt) ? tgt : p + 4;
            else         p = (p - 4 < tgt) ? tgt : p - 4;
            exp_q.push_back(p);
        end
    endtask

    task automatic wait_valid(input string name);
        int budget = 20;
        while (!taps_valid && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) check({name, "_timeout"}, 1, 0);
    endtask

    // Acks each offered triple after a random delay, checks every committed
    // step against the plan and checks the hold rule while stalled.
    task automatic run_ramp(input string name, input int tgt, input int max_dly, output int n);
        int budget = 3000;
        int wait_cnt = 0;
        int dly = 0;
        int nexp;
        int e;
        int held_post = -1;
        plan(tgt);
        nexp = exp_q.size();
        n = 0;
        while (budget > 0) begin
            @(negedge clk);
            budget--;
            taps_ack = 1'b0;
            if (locked && !taps_valid) break;
            if (taps_valid) begin
                if (held_post >= 0) check({name, "_hold"}, int'(tap_post), held_post);
                if (wait_cnt >= dly) begin
                    taps_ack = 1'b1;
                    n++;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
                    check({name, "_step"}, int'(tap_post), e);
                    check({name, "_sum"}, int'(tap_pre) + int'(tap_main) + int'(tap_post), 127);
                    if (e >= 0) model_post = e;
                    wait_cnt = 0;
                    dly = $urandom_range(0, max_dly);
                    held_post = -1;
                end else begin
                    wait_cnt++;
                    held_post = int'(tap_post);
                end
            end
        end
        taps_ack = 1'b0;
        if (budget == 0) check({name, "_timeout"}, 1, 0);
        check({name, "_xfers"}, n, nexp);
        check({name, "_locked"}, int'(locked), 1);
        check({name, "_post"}, int'(tap_post), tgt);
        check({name, "_pre"}, int'(tap_pre), tgt / 4);
        check({name, "_main"}, int'(tap_main), 127 - tgt / 4 - tgt);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int ok;
        int g0, gprev, g;
        logic [7:0] sp, sm, so;

        tbl[0] = '{g: 200, pre: 12, main: 65,  post: 50, xfers: 13};
        tbl[1] = '{g: 210, pre: 13, main: 62,  post: 52, xfers: 13};
        tbl[2] = '{g: 400, pre: 15, main: 49,  post: 63, xfers: 16};
        tbl[3] = '{g: 0,   pre: 0,  main: 127, post: 0,  xfers: 0};
        tbl[4] = '{g: 3,   pre: 0,  main: 127, post: 0,  xfers: 0};
        tbl[5] = '{g: 8,   pre: 0,  main: 125, post: 2,  xfers: 1};
        tbl[6] = '{g: 100, pre: 6,  main: 96,  post: 25, xfers: 7};

        // Asynchronous reset values, before any clock edge.
        #2 rst_n = 1'b0;
        #1;
        check("rst_pre", int'(tap_pre), 0);
        check("rst_main", int'(tap_main), 127);
        check("rst_post", int'(tap_post), 0);
        check("rst_valid", int'(taps_valid), 0);
        check("rst_locked", int'(locked), 0);

        for (int i = 0; i < 7; i++) begin
            do_reset();
            strobe4(tbl[i].g);
            run_ramp("tbl", ref_post(tbl[i].g), 2, n);
            check("tbl_xfers_const", n, tbl[i].xfers);
            check("tbl_pre_const", int'(tap_pre), tbl[i].pre);
            check("tbl_main_const", int'(tap_main), tbl[i].main);
            check("tbl_post_const", int'(tap_post), tbl[i].post);
        end

        // Tolerance window: reference stays 200, fifth strobe lands in RAMP.
        do_reset();
        strobe(200); strobe(201); strobe(199); strobe(202); strobe(201);
        run_ramp("tol", 50, 0, n);

        // Disagreeing guess restarts qualification at 210.
        do_reset();
        strobe(200); strobe(200); strobe4(210);
        run_ramp("restart", 52, 1, n);

        // Long stall mid-ramp, then next step two cycles after the ack.
        do_reset();
        strobe4(200);
        wait_valid("stall");
        check("stall_first", int'(tap_post), 4);
        sp = tap_pre; sm = tap_main; so = tap_post;
        ok = 1;
        repeat (20) begin
            @(negedge clk);
            if (!taps_valid || tap_pre != sp || tap_main != sm || tap_post != so) ok = 0;
        end
        check("stall_stable", ok, 1);
        taps_ack = 1'b1;
        @(negedge clk);
        taps_ack = 1'b0;
        check("stall_drop", int'(taps_valid), 0);
        @(negedge clk);
        check("stall_next_valid", int'(taps_valid), 1);
        check("stall_next_post", int'(tap_post), 8);
        model_post = 4;
        run_ramp("stall_rest", 50, 0, n);

        // Locked at 50: background guesses of 100, then retrain.
        strobe4(100);
`ifdef TX_FFE_RELOCK_EN
        run_ramp("relock", 25, 1, n);
`else
        repeat (20) @(negedge clk);
        check("locked_ignore_post", int'(tap_post), 50);
        check("locked_ignore_lock", int'(locked), 1);
        check("locked_ignore_valid", int'(taps_valid), 0);
`endif
        pulse_retrain();
        check("retrain_unlock", int'(locked), 0);
        strobe4(100);
        run_ramp("retrain", 25, 1, n);

        // Retrain during a stalled transfer is deferred until the ack.
        do_reset();
        strobe4(200);
        wait_valid("defer");
        pulse_retrain();
        check("defer_hold", int'(taps_valid), 1);
        taps_ack = 1'b1;
        @(negedge clk);
        taps_ack = 1'b0;
        ok = 1;
        repeat (5) begin
            @(negedge clk);
            if (taps_valid || locked) ok = 0;
        end
        check("defer_track", ok, 1);
        model_post = 4;
        strobe4(100);
        run_ramp("defer_ramp", 25, 1, n);

        // Disable with a transfer pending: handshake completes, then IDLE.
        do_reset();
        strobe4(200);
        wait_valid("dis");
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check("dis_pending", int'(taps_valid), 1);
        taps_ack = 1'b1;
        @(negedge clk);
        taps_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("dis_valid", int'(taps_valid), 0);
        check("dis_locked", int'(locked), 0);
        check("dis_post", int'(tap_post), 4);

        // Reset asserted mid-transfer.
        do_reset();
        strobe4(400);
        wait_valid("rstmid");
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_valid", int'(taps_valid), 0);
        check("rstmid_post", int'(tap_post), 0);
        check("rstmid_main", int'(tap_main), 127);
        check("rstmid_pre", int'(tap_pre), 0);
        check("rstmid_locked", int'(locked), 0);

        // Randomized chain of qualified targets with random ack delays.
        do_reset();
        gprev = 0;
        for (int t = 0; t < 10; t++) begin
            g0 = $urandom_range(0, 511);
            for (int k = 0; k < 50 && (g0 - gprev <= 4 && gprev - g0 <= 4); k++)
                g0 = $urandom_range(0, 511);
            if (g0 - gprev <= 4 && gprev - g0 <= 4) g0 = (gprev + 100) % 512;
            if (t > 0) pulse_retrain();
            strobe(g0);
            for (int k = 0; k < 3; k++) begin
                g = g0 + int'($urandom_range(0, 2)) - 1;
                if (g < 0) g = 0;
                if (g > 511) g = 511;
                strobe(g);
            end
            run_ramp("rnd", ref_post(g0), 3, n);
            gprev = g0;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
